// File: rtl/striping_sched.sv
// striping_sched: distributes an upstream word stream over two lanes.
// A burst opens from IDLE when valid_in rises with at least one lane enabled.
// The lane enable pattern is frozen for the whole burst. With both lanes
// enabled, accepted words alternate lane 0, lane 1, lane 0, ... from the start
// of the burst. Downstream almost-full on the target lane parks the FSM in
// STALL without losing its place in the alternation.
module striping_sched (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic [1:0]  lane_en,
  input  logic [1:0]  lane_afull,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [31:0] data_out_0,
  output logic [31:0] data_out_1,
  output logic        valid_out_0,
  output logic        valid_out_1,
  output logic [1:0]  state,
  output logic [7:0]  cnt_0,
  output logic [7:0]  cnt_1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t     fsm;
  logic       ptr;        // lane that receives the next accepted word
  logic [1:0] en_q;       // lane enables frozen for the current burst
  logic       afull_ptr;
  logic       accept;

  assign afull_ptr = lane_afull[ptr];
  // Gated by reset as well, so the handshake is closed immediately on reset
  // assertion regardless of where the clock is.
  assign ready_in  = ~reset & (fsm == ACTIVE) & ~afull_ptr;
  assign accept    = valid_in & ready_in;
  assign state     = fsm;

  // Burst control: state, lane pointer and the frozen enable pattern.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      fsm  <= IDLE;
      ptr  <= 1'b0;
      en_q <= 2'b00;
    end else begin
      case (fsm)
        IDLE: begin
          en_q <= lane_en;
          if (valid_in && (lane_en != 2'b00)) begin
            fsm <= ACTIVE;
            // first enabled lane; lane 0 wins when both are enabled
            ptr <= ~lane_en[0];
          end
        end
        ACTIVE: begin
          // an upstream gap ends the burst even if the lane is also full
          if (!valid_in) begin
            fsm <= IDLE;
          end else if (afull_ptr) begin
            fsm <= STALL;
          end else if (en_q == 2'b11) begin
            ptr <= ~ptr;
          end
        end
        STALL: begin
          if (!afull_ptr) begin
            fsm <= ACTIVE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Per-lane output registers and accepted-word counters.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam logic LANE = 1'(gi);
    logic [31:0] data_q;
    logic        valid_q;
    logic [7:0]  cnt_q;
    logic        hit;

    assign hit = accept & (ptr == LANE);

    // Capture the word headed for this lane; valid is a one-cycle pulse.
    always_ff @(posedge clk_2f or posedge reset) begin
      if (reset) begin
        data_q  <= 32'd0;
        valid_q <= 1'b0;
        cnt_q   <= 8'd0;
      end else begin
        valid_q <= hit;
        if (hit) begin
          data_q <= data_in;
          cnt_q  <= cnt_q + 8'd1;
        end
      end
    end
  end

  assign data_out_0  = g_lane[0].data_q;
  assign data_out_1  = g_lane[1].data_q;
  assign valid_out_0 = g_lane[0].valid_q;
  assign valid_out_1 = g_lane[1].valid_q;
  assign cnt_0       = g_lane[0].cnt_q;
  assign cnt_1       = g_lane[1].cnt_q;

endmodule

// File: doc/striping_sched.md
STRIPING_SCHED -- requirements
Module: striping_sched

Interface
REQ-001 The block SHALL have one clock, clk_2f, and the reset SHALL be asynchronous and active-high, named reset.
REQ-002 Ports SHALL be, clock and reset first:
- clk_2f  input  1  striping-domain clock
- reset  input  1  asynchronous, active-high reset
- lane_en  input  2  lane enable configuration; bit n enables lane n
- lane_afull  input  2  almost-full from downstream lane FIFOs; bit n for lane n
- data_in  input  32  word from the recirculator active path
- valid_in  input  1  data_in is valid
- ready_in  output  1  word accepted this cycle when valid_in=1 and ready_in=1
- data_out_0, data_out_1  output  32 each  lane data, registered
- valid_out_0, valid_out_1  output  1 each  lane valid, registered
- state  output  2  FSM state
- cnt_0, cnt_1  output  8 each  accepted-word count per lane

Function
REQ-003 The FSM SHALL have three states, encoded on state as IDLE=0, ACTIVE=1, STALL=2; code 3 is unreachable and SHALL return to IDLE on the next edge.
REQ-004 The block SHALL hold a shadow register, en_q, that loads lane_en on every clk_2f edge while in IDLE and holds its value in ACTIVE and STALL.
REQ-005 Transition IDLE -> ACTIVE SHALL occur when valid_in=1 and lane_en!=0 in the same cycle; ptr SHALL load 0 if lane_en[0]=1, else 1.
REQ-006 The target lane SHALL be ptr; ptr SHALL always point to an enabled lane in en_q.
REQ-007 ready_in SHALL be combinational and SHALL equal (state==ACTIVE) and (lane_afull[ptr]==0); it SHALL be 0 in IDLE and STALL.
REQ-008 On an accept (ACTIVE, valid_in=1, ready_in=1), the next edge SHALL:
- set data_out_ptr to data_in and valid_out_ptr to 1, and valid_out of the other lane to 0
- increment cnt_ptr by 1 (mod 256, 255 wraps to 0)
- toggle ptr if en_q==2'b11, else leave ptr unchanged
REQ-009 On every cycle without an accept, both valid_out SHALL be 0 on the next edge.
REQ-010 data_out_n SHALL hold its last value when valid_out_n=0.
REQ-011 Output latency SHALL be exactly one clk_2f cycle from accept to valid_out.
REQ-012 ACTIVE transitions:
- valid_in=0 -> IDLE
- valid_in=1 and lane_afull[ptr]=1 -> STALL, with no accept
- otherwise -> stay in ACTIVE
REQ-013 valid_in=0 SHALL take priority over lane_afull for the ACTIVE transition.
REQ-014 STALL transitions:
- lane_afull[ptr]=0 -> ACTIVE, with no accept in the STALL cycle
- otherwise -> stay in STALL
- ptr and the counters SHALL NOT change in STALL
REQ-015 A lane_en change during ACTIVE or STALL SHALL have no effect until the FSM returns to IDLE.
REQ-016 With en_q==2'b11, consecutive accepts SHALL alternate lanes strictly, 0,1,0,1..., starting at lane 0 for each burst; a STALL SHALL NOT break the alternation.
REQ-017 The upstream source SHALL hold data_in stable while valid_in=1 and ready_in=0; the block SHALL NOT capture data_in in that case.

Reset
REQ-018 While reset=1, asynchronously and independent of clk_2f, the block SHALL force: state=IDLE, ptr=0, en_q=0, both valid_out=0, both data_out=0, both cnt=0.
REQ-019 ready_in SHALL be 0 while reset=1.
REQ-020 Reset asserted mid-burst SHALL discard any in-flight word with no valid_out pulse; after release the FSM SHALL restart from IDLE.

Verification
REQ-021 Bench SHALL cover:
- lane_en=3, valid_in=1 for 4 cycles with data 0xA0..0xA3 -> IDLE->ACTIVE; outputs lane0 0xA0, lane1 0xA1, lane0 0xA2; cnt_0=2, cnt_1=1; valid_in drop -> IDLE.
- lane_en=2, burst of 3 words -> all on lane 1; cnt_1=3, cnt_0=0; valid_out_0 never 1.
- lane_en=3, lane_afull=2'b10 during the second word -> STALL, ready_in=0, data held; afull release -> ACTIVE, word goes to lane 1, then next word to lane 0.
- lane_en changed 3->1 mid-burst -> alternation continues until IDLE; the next burst uses lane 0 only.
- 256 accepts on lane 0 -> cnt_0 wraps to 0.
- reset pulse asserted between clock edges mid-burst -> all outputs 0 immediately, state=0, no valid_out pulse after release until a new valid_in.
